// File: rtl/triangle_vertex_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : triangle_vertex_loader_pkg
// Purpose : Shared definitions for the triangle vertex loader: host write
//           index map, FSM state encodings, velocity field layout and the
//           velocity sign-extension helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package triangle_vertex_loader_pkg;

   // Host write index map
   localparam logic [2:0] IDX_X0     = 3'd0;
   localparam logic [2:0] IDX_Y0     = 3'd1;
   localparam logic [2:0] IDX_X1     = 3'd2;
   localparam logic [2:0] IDX_Y1     = 3'd3;
   localparam logic [2:0] IDX_X2     = 3'd4;
   localparam logic [2:0] IDX_Y2     = 3'd5;
   localparam logic [2:0] IDX_VEL    = 3'd6;
   localparam logic [2:0] IDX_COMMIT = 3'd7;

   // Velocity word layout: [7:0] = dx, [15:8] = dy, both signed
   localparam int VEL_W      = 8;
   localparam int VEL_DX_LSB = 0;
   localparam int VEL_DY_LSB = 8;

   localparam logic signed [VEL_W-1:0] VEL_DX_INIT = 8'sd2;
   localparam logic signed [VEL_W-1:0] VEL_DY_INIT = 8'sd1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   function automatic logic signed [31:0] vel_sext(input logic signed [VEL_W-1:0] v);
      return $signed({{(32-VEL_W){v[VEL_W-1]}}, v});
   endfunction

endpackage
`default_nettype wire

// File: rtl/triangle_vertex_loader_axis_bounce.sv
`default_nettype none
// ============================================================================
// Module  : triangle_vertex_loader_axis_bounce
// Purpose : Per-axis edge bounce decision. Tries coord+vel for all three
//           vertices; if any result leaves [0, ACTIVE-1] the axis holds still
//           this frame and its velocity is negated.
// Ports   : coord0..coord2 (in, 32)  current live coordinates on this axis
//           vel            (in, 8)   signed velocity on this axis
//           move_en        (out, 1)  apply vel to all coordinates this frame
//           vel_next       (out, 8)  velocity to hold after this frame
// Revision: 1.0 - initial release
// ============================================================================
module triangle_vertex_loader_axis_bounce
   import triangle_vertex_loader_pkg::*;
#(
   parameter int ACTIVE = 1280
)(
   input  logic [31:0]              coord0,
   input  logic [31:0]              coord1,
   input  logic [31:0]              coord2,
   input  logic signed [VEL_W-1:0]  vel,
   output logic                     move_en,
   output logic signed [VEL_W-1:0]  vel_next
);

   localparam logic signed [31:0] c_limit = 32'(ACTIVE - 1);

   logic signed [31:0] w_vel_ext;
   logic signed [31:0] w_n0;
   logic signed [31:0] w_n1;
   logic signed [31:0] w_n2;
   logic               w_out;

   assign w_vel_ext = vel_sext(vel);
   // Coordinates are below 2^31, so the signed view of the sum is exact.
   assign w_n0 = $signed(coord0) + w_vel_ext;
   assign w_n1 = $signed(coord1) + w_vel_ext;
   assign w_n2 = $signed(coord2) + w_vel_ext;

   assign w_out = (w_n0 < 0) || (w_n0 > c_limit) ||
                  (w_n1 < 0) || (w_n1 > c_limit) ||
                  (w_n2 < 0) || (w_n2 > c_limit);

   assign move_en  = ~w_out;
   assign vel_next = w_out ? -vel : vel;

endmodule
`default_nettype wire

// File: rtl/triangle_vertex_loader.sv
`default_nettype none
// ============================================================================
// Module  : triangle_vertex_loader
// Purpose : Holds the three triangle vertices feeding the raster stage.
//           Host writes land in a shadow set; a commit request arms the FSM
//           and the shadow set is copied to the live outputs right after the
//           next VSync rising edge, so a frame never tears.
//           Optional per-frame drift with edge bounce: define TRI_ANIMATE_EN.
// Ports   : pixel_clk, rst_n (async active-low)   clock / reset
//           vsync                                  VSync from raster stage
//           wr_valid/wr_ready/wr_idx/wr_data       host write channel
//           anim_en                                enable drift (macro only)
//           x0,y0,x1,y1,x2,y2                      live vertex coordinates
//           pending                                commit armed, not applied
//           frame_tick                             pulse per VSync rise
//           wr_err                                 sticky unsupported index
// Revision: 1.0 - initial release
// ============================================================================
module triangle_vertex_loader
   import triangle_vertex_loader_pkg::*;
#(
   parameter int H_ACTIVE_VIDEO = 1280,
   parameter int V_ACTIVE_VIDEO = 720,
   parameter int X0_INIT        = 640,
   parameter int Y0_INIT        = 100,
   parameter int X1_INIT        = 340,
   parameter int Y1_INIT        = 600,
   parameter int X2_INIT        = 940,
   parameter int Y2_INIT        = 600
)(
   input  logic        pixel_clk,
   input  logic        rst_n,
   input  logic        vsync,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [2:0]  wr_idx,
   input  logic [31:0] wr_data,
   input  logic        anim_en,
   output logic [31:0] x0,
   output logic [31:0] y0,
   output logic [31:0] x1,
   output logic [31:0] y1,
   output logic [31:0] x2,
   output logic [31:0] y2,
   output logic        pending,
   output logic        frame_tick,
   output logic        wr_err
);

   localparam logic [31:0] c_x_init [3] = '{32'(X0_INIT), 32'(X1_INIT), 32'(X2_INIT)};
   localparam logic [31:0] c_y_init [3] = '{32'(Y0_INIT), 32'(Y1_INIT), 32'(Y2_INIT)};

   state_t                   r_state;
   state_t                   w_state_next;
   logic                     r_vsync_q;
   logic                     r_frame_tick;
   logic                     r_wr_err;
   logic                     w_rise;
   logic                     w_xfer;
   logic                     w_commit;
   logic [31:0]              r_shx [3];
   logic [31:0]              r_shy [3];
   logic [31:0]              r_lx  [3];
   logic [31:0]              r_ly  [3];
   logic signed [VEL_W-1:0]  w_dx;
   logic signed [VEL_W-1:0]  w_dy;
   logic signed [VEL_W-1:0]  w_dx_next;
   logic signed [VEL_W-1:0]  w_dy_next;
   logic                     w_x_move;
   logic                     w_y_move;

   assign w_rise = vsync & ~r_vsync_q;
   assign w_xfer = wr_valid & wr_ready;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      wr_ready     = 1'b0;
      pending      = 1'b0;
      w_commit     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            wr_ready = 1'b1;
            if (wr_valid && (wr_idx == IDX_COMMIT)) w_state_next = ST_ARMED;
         end
         ST_ARMED: begin
            pending = 1'b1;
            if (w_rise) w_state_next = ST_COMMIT;
         end
         ST_COMMIT: begin
            w_commit     = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------ bounce checks
   triangle_vertex_loader_axis_bounce #(.ACTIVE(H_ACTIVE_VIDEO)) u_bounce_x (
      .coord0   (r_lx[0]),
      .coord1   (r_lx[1]),
      .coord2   (r_lx[2]),
      .vel      (w_dx),
      .move_en  (w_x_move),
      .vel_next (w_dx_next)
   );

   triangle_vertex_loader_axis_bounce #(.ACTIVE(V_ACTIVE_VIDEO)) u_bounce_y (
      .coord0   (r_ly[0]),
      .coord1   (r_ly[1]),
      .coord2   (r_ly[2]),
      .vel      (w_dy),
      .move_en  (w_y_move),
      .vel_next (w_dy_next)
   );

`ifdef TRI_ANIMATE_EN
   logic signed [VEL_W-1:0] r_dx;
   logic signed [VEL_W-1:0] r_dy;
   logic                    w_anim_step;

   assign w_dx = r_dx;
   assign w_dy = r_dy;
   // A rise that moves ARMED to COMMIT belongs to the commit, not to drift.
   assign w_anim_step = w_rise & anim_en & (r_state != ST_ARMED) & ~w_commit;

   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dx <= VEL_DX_INIT;
         r_dy <= VEL_DY_INIT;
      end else if (w_xfer && (wr_idx == IDX_VEL)) begin
         r_dx <= wr_data[VEL_DX_LSB +: VEL_W];
         r_dy <= wr_data[VEL_DY_LSB +: VEL_W];
      end else if (w_anim_step) begin
         r_dx <= w_dx_next;
         r_dy <= w_dy_next;
      end
   end
`else
   logic w_anim_step;
   logic w_unused_anim;

   assign w_dx          = VEL_DX_INIT;
   assign w_dy          = VEL_DY_INIT;
   assign w_anim_step   = 1'b0;
   assign w_unused_anim = ^{anim_en, w_x_move, w_y_move, w_dx_next, w_dy_next};
`endif

   // ---------------------------------------------------- datapath regs
   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vsync_q    <= 1'b0;
         r_frame_tick <= 1'b0;
         r_wr_err     <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            r_shx[i] <= c_x_init[i];
            r_shy[i] <= c_y_init[i];
            r_lx[i]  <= c_x_init[i];
            r_ly[i]  <= c_y_init[i];
         end
      end else begin
         r_vsync_q    <= vsync;
         r_frame_tick <= w_rise;

         if (w_xfer) begin
            case (wr_idx)
               IDX_X0:  r_shx[0] <= wr_data;
               IDX_Y0:  r_shy[0] <= wr_data;
               IDX_X1:  r_shx[1] <= wr_data;
               IDX_Y1:  r_shy[1] <= wr_data;
               IDX_X2:  r_shx[2] <= wr_data;
               IDX_Y2:  r_shy[2] <= wr_data;
`ifndef TRI_ANIMATE_EN
               IDX_VEL: r_wr_err <= 1'b1;
`endif
               default: ;
            endcase
         end

         if (w_commit) begin
            for (int i = 0; i < 3; i++) begin
               r_lx[i] <= r_shx[i];
               r_ly[i] <= r_shy[i];
            end
         end else if (w_anim_step) begin
            for (int i = 0; i < 3; i++) begin
               if (w_x_move) r_lx[i] <= r_lx[i] + 32'(vel_sext(w_dx));
               if (w_y_move) r_ly[i] <= r_ly[i] + 32'(vel_sext(w_dy));
            end
         end
      end
   end

   assign x0         = r_lx[0];
   assign y0         = r_ly[0];
   assign x1         = r_lx[1];
   assign y1         = r_ly[1];
   assign x2         = r_lx[2];
   assign y2         = r_ly[2];
   assign frame_tick = r_frame_tick;
   assign wr_err     = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_triangle_vertex_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_triangle_vertex_loader
// Purpose : Directed self-checking bench for triangle_vertex_loader.
// Revision: 1.0 - initial release
// ============================================================================
module tb_triangle_vertex_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        vsync = 1'b0;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [2:0]  wr_idx = 3'd0;
   logic [31:0] wr_data = 32'd0;
   logic        anim_en = 1'b0;
   logic [31:0] x0, y0, x1, y1, x2, y2;
   logic        pending, frame_tick, wr_err;

   int errors = 0;
   int checks = 0;
   int ticks  = 0;

   always #5 clk = ~clk;

   triangle_vertex_loader dut (
      .pixel_clk  (clk),
      .rst_n      (rst_n),
      .vsync      (vsync),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_idx     (wr_idx),
      .wr_data    (wr_data),
      .anim_en    (anim_en),
      .x0         (x0),
      .y0         (y0),
      .x1         (x1),
      .y1         (y1),
      .x2         (x2),
      .y2         (y2),
      .pending    (pending),
      .frame_tick (frame_tick),
      .wr_err     (wr_err)
   );

   always @(negedge clk) if (rst_n && frame_tick) ticks++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_live(input string tag, input int ex0, input int ey0, input int ex1,
                             input int ey1, input int ex2, input int ey2);
      check({tag, ".x0"}, x0, 32'(ex0));
      check({tag, ".y0"}, y0, 32'(ey0));
      check({tag, ".x1"}, x1, 32'(ex1));
      check({tag, ".y1"}, y1, 32'(ey1));
      check({tag, ".x2"}, x2, 32'(ex2));
      check({tag, ".y2"}, y2, 32'(ey2));
   endtask

   // Drive one write at a negedge and hold it until accepted (bounded).
   task automatic host_write(input logic [2:0] idx, input logic [31:0] data);
      bit done = 0;
      @(negedge clk);
      wr_valid = 1'b1; wr_idx = idx; wr_data = data;
      for (int n = 0; n < 50 && !done; n++) begin
         if (wr_ready) done = 1;
         @(negedge clk);
      end
      wr_valid = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $error("FAIL write_timeout observed=stalled expected=accepted idx=%0d", idx);
      end
   endtask

   // One VSync pulse: high for 4 cycles, low for 4 cycles.
   task automatic vsync_pulse();
      @(negedge clk); vsync = 1'b1;
      repeat (4) @(negedge clk);
      vsync = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk); rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      // 1: reset, then also asserted mid-frame with vsync high
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); vsync = 1'b1;
      @(negedge clk); rst_n = 1'b0;
      #1;
      check_live("reset", 640, 100, 340, 600, 940, 600);
      check("reset.wr_ready", 32'(wr_ready), 1);
      check("reset.pending", 32'(pending), 0);
      check("reset.wr_err", 32'(wr_err), 0);
      check("reset.frame_tick", 32'(frame_tick), 0);
      vsync = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);

      // 2: write x0, arm, commit on vsync rise with exact latency
      host_write(3'd0, 32'd100);
      host_write(3'd7, 32'd0);
      check("arm.pending", 32'(pending), 1);
      check("arm.wr_ready", 32'(wr_ready), 0);
      repeat (3) @(negedge clk);
      check("arm.x0_held", x0, 32'd640);
      vsync = 1'b1;
      @(posedge clk); #1;
      check("commit.x0_1cyc", x0, 32'd640);
      check("commit.tick", 32'(frame_tick), 1);
      @(posedge clk); #1;
      check("commit.x0_2cyc", x0, 32'd100);
      check("commit.pending", 32'(pending), 0);
      check("commit.wr_ready", 32'(wr_ready), 1);
      check("commit.tick_off", 32'(frame_tick), 0);
      @(negedge clk); vsync = 1'b0;
      repeat (3) @(negedge clk);

      // 3: write held while ARMED stalls until after COMMIT
      host_write(3'd7, 32'd0);
      @(negedge clk);
      wr_valid = 1'b1; wr_idx = 3'd1; wr_data = 32'd50;
      repeat (3) begin
         check("stall.wr_ready", 32'(wr_ready), 0);
         @(negedge clk);
      end
      vsync = 1'b1;
      @(negedge clk);
      check("stall.in_commit", 32'(wr_ready), 0);
      @(negedge clk);
      check("stall.released", 32'(wr_ready), 1);
      @(negedge clk);
      wr_valid = 1'b0;
      vsync = 1'b0;
      check("stall.y0_live", y0, 32'd100);
      check("stall.x0_live", x0, 32'd100);
      host_write(3'd7, 32'd0);
      vsync_pulse();
      check("stall.y0_shadow", y0, 32'd50);

      // reset while ARMED abandons the commit
      host_write(3'd2, 32'd7);
      host_write(3'd7, 32'd0);
      do_reset();
      check("rst_armed.pending", 32'(pending), 0);
      vsync_pulse();
      check_live("rst_armed", 640, 100, 340, 600, 940, 600);

`ifdef TRI_ANIMATE_EN
      // 4: three animated frames with default velocity (+2,+1)
      anim_en = 1'b1;
      ticks = 0;
      repeat (3) vsync_pulse();
      check("anim.x0", x0, 32'd646);
      check("anim.y0", y0, 32'd103);
      check("anim.x2", x2, 32'd946);
      check("anim.ticks", 32'(ticks), 3);

      // 5: bounce on the right edge
      anim_en = 1'b0;
      do_reset();
      host_write(3'd4, 32'd1278);
      host_write(3'd7, 32'd0);
      vsync_pulse();
      check("bounce.x2_set", x2, 32'd1278);
      anim_en = 1'b1;
      vsync_pulse();
      check_live("bounce.f1", 640, 101, 340, 601, 1278, 601);
      vsync_pulse();
      check_live("bounce.f2", 638, 102, 338, 602, 1276, 602);
      anim_en = 1'b0;
`else
      // 6: velocity write is accepted, flagged, and drift never happens
      anim_en = 1'b1;
      host_write(3'd6, 32'h0000_0305);
      check("vel.wr_err", 32'(wr_err), 1);
      check("vel.wr_ready", 32'(wr_ready), 1);
      ticks = 0;
      repeat (5) vsync_pulse();
      check_live("noanim", 640, 100, 340, 600, 940, 600);
      check("noanim.ticks", 32'(ticks), 5);
      check("noanim.wr_err_sticky", 32'(wr_err), 1);
      do_reset();
      check("noanim.wr_err_clr", 32'(wr_err), 0);
      anim_en = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
